// File: rtl/prng_sched_pkg.sv
// Shared constants, FSM state type and the xorshift32 step used by the PRNG request scheduler.
package prng_sched_pkg;

  localparam int XS_A = 13;
  localparam int XS_B = 17;
  localparam int XS_C = 5;

  typedef enum logic [1:0] {IDLE, GEN, DONE} state_t;

  function automatic logic [31:0] xs(input logic [31:0] x);
    logic [31:0] t;
    t = x ^ (x << XS_A);
    t = t ^ (t >> XS_B);
    return t ^ (t << XS_C);
  endfunction

endpackage

// File: rtl/prng_req_scheduler_if.sv
// Requester/FIFO-side bundle of the PRNG request scheduler; master = requesters+FIFO, slave = scheduler.
// Handshake: a request on lane i is accepted in the cycle where req_valid[i] && req_ready[i];
// an output word moves in the cycle where out_valid && !fifo_full. Senders hold payload until accepted.
interface prng_req_scheduler_if #(
  parameter int NUM_REQ = 4,
  parameter int LEN_W   = 9,
  parameter int ID_W    = $clog2(NUM_REQ)
);
  import prng_sched_pkg::*;

  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ*32-1:0]    req_seed;
  logic [NUM_REQ*LEN_W-1:0] req_len;
  logic [NUM_REQ-1:0]       req_ready;
  logic                     fifo_full;
  logic                     out_valid;
  logic [31:0]              out_data;
  logic [ID_W-1:0]          out_id;
  logic                     out_last;
  logic                     busy;
  logic [NUM_REQ-1:0]       done;
  state_t                   state_dbg;

  modport master (
    output req_valid, req_seed, req_len, fifo_full,
    input  req_ready, out_valid, out_data, out_id, out_last, busy, done, state_dbg
  );

  modport slave (
    input  req_valid, req_seed, req_len, fifo_full,
    output req_ready, out_valid, out_data, out_id, out_last, busy, done, state_dbg
  );

endinterface

// File: rtl/prng_xorshift32_step.sv
// One combinational xorshift32 step (13/17/5 shifts).
module prng_xorshift32_step
  import prng_sched_pkg::*;
(
  input  logic [31:0] din,
  output logic [31:0] dout
);

  assign dout = xs(din);

endmodule

// File: rtl/prng_req_scheduler.sv
// Round-robin scheduler sharing one xorshift32 generator among NUM_REQ seed requesters.
// Optional build macro PRNG_ZERO_SEED_GUARD_EN: a zero seed is replaced by 32'h1 at capture.
module prng_req_scheduler
  import prng_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int LEN_W   = 9,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic clk,
  input  logic rst,
  prng_req_scheduler_if.slave bus
);

  state_t             state_q, state_d;
  logic [ID_W-1:0]    ptr_q, ptr_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        data_q, data_d;
  logic               valid_q, valid_d;
  logic               last_q, last_d;
  logic [NUM_REQ-1:0] req_ready;

  logic               grant_any;
  logic [ID_W-1:0]    grant_id;
  logic [31:0]        cap_seed;
  logic [31:0]        seed_eff;
  logic [LEN_W-1:0]   cap_len;
  logic [31:0]        step_in;
  logic [31:0]        step_out;

  // Scan downward so the lowest offset from the pointer is written last and wins.
  always_comb begin
    grant_any = 1'b0;
    grant_id  = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (bus.req_valid[ID_W'(ptr_q + ID_W'(k))]) begin
        grant_any = 1'b1;
        grant_id  = ID_W'(ptr_q + ID_W'(k));
      end
    end
  end

  assign cap_seed = bus.req_seed[32*grant_id +: 32];
  assign cap_len  = bus.req_len[LEN_W*grant_id +: LEN_W];

`ifdef PRNG_ZERO_SEED_GUARD_EN
  assign seed_eff = (cap_seed == 32'h0) ? 32'h0000_0001 : cap_seed;
`else
  assign seed_eff = cap_seed;
`endif

  // The single generator step seeds from the captured seed in IDLE, otherwise feeds back.
  assign step_in = (state_q == IDLE) ? seed_eff : data_q;

  prng_xorshift32_step u_step (
    .din  (step_in),
    .dout (step_out)
  );

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    id_d      = id_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    valid_d   = valid_q;
    last_d    = last_q;
    req_ready = '0;
    case (state_q)
      IDLE: begin
        if (grant_any) begin
          req_ready[grant_id] = 1'b1;
          id_d  = grant_id;
          ptr_d = ID_W'(grant_id + 1'b1);
          len_d = cap_len;
          cnt_d = '0;
          if (cap_len != '0) begin
            state_d = GEN;
            data_d  = step_out;
            valid_d = 1'b1;
            last_d  = (cap_len == LEN_W'(1));
          end else begin
            state_d = DONE;
          end
        end
      end
      GEN: begin
        if (valid_q && !bus.fifo_full) begin
          data_d = step_out;
          cnt_d  = cnt_q + 1'b1;
          if (last_q) begin
            state_d = DONE;
            valid_d = 1'b0;
            last_d  = 1'b0;
          end else begin
            // Next count equals len-1, i.e. the word after this transfer is the final one.
            last_d = (({1'b0, cnt_q} + (LEN_W+1)'(2)) == {1'b0, len_q});
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

  assign bus.req_ready = req_ready;
  assign bus.out_valid = valid_q;
  assign bus.out_data  = data_q;
  assign bus.out_id    = id_q;
  assign bus.out_last  = last_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = (state_q == DONE) ? (NUM_REQ'(1) << id_q) : '0;
  assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_prng_req_scheduler.sv
// Bench for prng_req_scheduler: transaction-level model (expected word queue per grant) compared every cycle.
module tb_prng_req_scheduler;
  import prng_sched_pkg::*;

  localparam int N  = 4;
  localparam int LW = 9;
  localparam int IW = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  prng_req_scheduler_if #(.NUM_REQ(N), .LEN_W(LW), .ID_W(IW)) intf ();

  prng_req_scheduler #(.NUM_REQ(N), .LEN_W(LW), .ID_W(IW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (intf)
  );

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Arithmetic form of xorshift32: multiply/divide by powers of two with 32-bit wrap.
  function automatic logic [31:0] xs_m(input logic [31:0] x);
    logic [31:0] a;
    a = x ^ 32'(x * 32'd8192);
    a = a ^ (a / 32'd131072);
    a = a ^ 32'(a * 32'd32);
    return a;
  endfunction

  function automatic int pick(input int ptr, input logic [N-1:0] v);
    for (int k = 0; k < N; k++)
      if (v[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  function automatic logic [31:0] seed_use(input logic [31:0] s);
`ifdef PRNG_ZERO_SEED_GUARD_EN
    if (s == 32'h0) return 32'h1;
`endif
    return s;
  endfunction

  logic [31:0] exp_q[$];
  int m_phase = 0;   // 0 waiting for a grant, 1 emitting words, 2 completion cycle
  int m_ptr   = 0;
  int m_id    = 0;
  int m_g, m_len;
  logic [31:0] m_w;
  logic [N-1:0] rdy_last = '0;

  always @(posedge clk) rdy_last <= intf.req_ready;

  always @(posedge clk) begin
    if (rst) begin
      m_phase = 0;
      m_ptr   = 0;
      m_id    = 0;
      exp_q.delete();
    end else begin
      case (m_phase)
        0: begin
          m_g = pick(m_ptr, intf.req_valid);
          if (m_g >= 0) begin
            m_id  = m_g;
            m_ptr = (m_g + 1) % N;
            m_w   = seed_use(intf.req_seed[32*m_g +: 32]);
            m_len = int'(intf.req_len[LW*m_g +: LW]);
            for (int k = 0; k < m_len; k++) begin
              m_w = xs_m(m_w);
              exp_q.push_back(m_w);
            end
            m_phase = (m_len != 0) ? 1 : 2;
          end
        end
        1: begin
          if (!intf.fifo_full) begin
            void'(exp_q.pop_front());
            if (exp_q.size() == 0) m_phase = 2;
          end
        end
        default: m_phase = 0;
      endcase
    end
  end

  // ---------------- scoreboard compare ----------------
  logic [N-1:0] e_ready;
  int e_g;
  always @(negedge clk) begin
    if (chk_en) begin
      e_ready = '0;
      e_g = pick(m_ptr, intf.req_valid);
      if (m_phase == 0 && e_g >= 0) e_ready[e_g] = 1'b1;
      chk("req_ready", 32'(intf.req_ready), 32'(e_ready));
      chk("out_valid", 32'(intf.out_valid), 32'(m_phase == 1));
      if (m_phase == 1 && exp_q.size() > 0) chk("out_data", intf.out_data, exp_q[0]);
      chk("out_last", 32'(intf.out_last), 32'(m_phase == 1 && exp_q.size() == 1));
      chk("out_id", 32'(intf.out_id), 32'(m_id));
      chk("busy", 32'(intf.busy), 32'(m_phase != 0));
      chk("done", 32'(intf.done), (m_phase == 2) ? (32'(1) << m_id) : 32'(0));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  task automatic set_req(input int i, input logic [31:0] seed, input int len);
    intf.req_valid[i] = 1'b1;
    intf.req_seed[32*i +: 32] = seed;
    intf.req_len[LW*i +: LW] = LW'(len);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    intf.req_valid = '0;
    intf.fifo_full = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    neg();
    while (intf.busy && n < 100) begin
      tick();
      neg();
      n++;
    end
    chk("idle_timeout", 32'(intf.busy), 32'(0));
  endtask

  task automatic serve(input int exp_id);
    int n;
    n = 0;
    neg();
    while (intf.req_ready == '0 && n < 50) begin
      tick();
      neg();
      n++;
    end
    chk("grant", 32'(intf.req_ready), 32'(1) << exp_id);
    tick();
    intf.req_valid[exp_id] = 1'b0;
    neg();
    chk("grant_id", 32'(intf.out_id), 32'(exp_id));
  endtask

  // ---------------- main sequence ----------------
  int words;
  logic [31:0] s5;

  initial begin
    intf.req_valid = '0;
    intf.req_seed  = '0;
    intf.req_len   = '0;
    intf.fifo_full = 1'b0;

    // reset state
    do_reset();
    neg();
    chk("rst_valid", 32'(intf.out_valid), 32'(0));
    chk("rst_data", intf.out_data, 32'(0));
    chk("rst_id", 32'(intf.out_id), 32'(0));
    chk("rst_last", 32'(intf.out_last), 32'(0));
    chk("rst_busy", 32'(intf.busy), 32'(0));
    chk("rst_done", 32'(intf.done), 32'(0));
    chk_en = 1'b1;

    // seed=1, len=3 on requester 0
    tick();
    set_req(0, 32'h1, 3);
    neg();
    chk("t1_ready", 32'(intf.req_ready), 32'h1);
    tick();
    intf.req_valid[0] = 1'b0;
    neg();
    chk("t1_w0", intf.out_data, 32'h0004_2021);
    tick(); neg();
    chk("t1_w1", intf.out_data, 32'h0408_0601);
    tick(); neg();
    chk("t1_last", 32'(intf.out_last), 32'h1);
    tick(); neg();
    chk("t1_done", 32'(intf.done), 32'h1);
    tick(); neg();
    chk("t1_idle", 32'(intf.busy), 32'h0);

    // round-robin order
    do_reset();
    set_req(0, $urandom, 1);
    set_req(2, $urandom, 1);
    serve(0);
    serve(2);
    tick();
    for (int i = 0; i < N; i++) set_req(i, $urandom, 1);
    serve(3);
    serve(0);
    serve(1);
    serve(2);
    wait_idle();

    // backpressure: len=4, fifo_full for 5 cycles after the first word
    tick();
    set_req(1, 32'h1234_5678, 4);
    neg();
    tick();
    intf.req_valid[1] = 1'b0;
    intf.fifo_full = 1'b1;
    for (int s = 0; s < 5; s++) begin
      neg();
      chk("stall_valid", 32'(intf.out_valid), 32'h1);
      chk("stall_data", intf.out_data, xs_m(32'h1234_5678));
      tick();
    end
    intf.fifo_full = 1'b0;
    words = 0;
    for (int c = 0; c < 20; c++) begin
      neg();
      if (intf.done != '0) break;
      if (intf.out_valid) words++;
      tick();
    end
    chk("stall_words", 32'(words), 32'd4);
    chk("stall_done", 32'(intf.done), 32'h2);
    wait_idle();

    // len=0
    tick();
    set_req(2, 32'h7, 0);
    neg();
    chk("len0_ready", 32'(intf.req_ready), 32'h4);
    tick();
    intf.req_valid[2] = 1'b0;
    neg();
    chk("len0_novalid", 32'(intf.out_valid), 32'h0);
    chk("len0_done", 32'(intf.done), 32'h4);
    tick(); neg();
    chk("len0_idle", 32'(intf.busy), 32'h0);

    // reset during word 2 of a len=8 request
    wait_idle();
    tick();
    s5 = $urandom;
    set_req(2, s5, 8);
    neg();
    tick();
    intf.req_valid[2] = 1'b0;
    neg();
    tick();
    rst = 1'b1;
    neg();
    chk("abort_w1", intf.out_data, xs_m(xs_m(seed_use(s5))));
    tick();
    rst = 1'b0;
    neg();
    chk("abort_valid", 32'(intf.out_valid), 32'h0);
    chk("abort_data", intf.out_data, 32'h0);
    chk("abort_last", 32'(intf.out_last), 32'h0);
    chk("abort_id", 32'(intf.out_id), 32'h0);
    chk("abort_busy", 32'(intf.busy), 32'h0);
    chk("abort_done", 32'(intf.done), 32'h0);
    tick(); neg();
    chk("abort_nodone", 32'(intf.done), 32'h0);
    tick();
    for (int i = 0; i < N; i++) set_req(i, $urandom, 1);
    serve(0);
    serve(1);
    serve(2);
    serve(3);
    wait_idle();

    // zero seed
    tick();
    set_req(3, 32'h0, 2);
    neg();
    tick();
    intf.req_valid[3] = 1'b0;
    neg();
`ifdef PRNG_ZERO_SEED_GUARD_EN
    chk("zseed_w0", intf.out_data, 32'h0004_2021);
    tick(); neg();
    chk("zseed_w1", intf.out_data, 32'h0408_0601);
`else
    chk("zseed_w0", intf.out_data, 32'h0);
    tick(); neg();
    chk("zseed_w1", intf.out_data, 32'h0);
`endif
    wait_idle();

    // randomized traffic with random backpressure
    for (int c = 0; c < 600; c++) begin
      tick();
      for (int i = 0; i < N; i++) begin
        if (intf.req_valid[i] && rdy_last[i]) begin
          intf.req_valid[i] = 1'b0;
        end else if (!intf.req_valid[i] && $urandom_range(0, 3) == 0) begin
          set_req(i, ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom, $urandom_range(0, 6));
        end
      end
      intf.fifo_full = ($urandom_range(0, 3) == 0);
    end
    tick();
    for (int i = 0; i < N; i++)
      if (rdy_last[i]) intf.req_valid[i] = 1'b0;
    intf.fifo_full = 1'b0;
    for (int c = 0; c < 80 && intf.req_valid != '0; c++) begin
      tick();
      for (int i = 0; i < N; i++)
        if (rdy_last[i]) intf.req_valid[i] = 1'b0;
    end
    chk("drain_valid", 32'(intf.req_valid), 32'h0);
    wait_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
